data_mem: RTL and testbench

//  Byte-addressable data RAM of the RISC-V practicum core (4 KiB); sits on the LSU data port.
//  - Little-endian 32-bit word writes and reads at any byte address, including misaligned ones.
//  - Read port is registered: 1-cycle synchronous read.
//  - Idle/write cycles return a fixed filler word; out-of-range reads return a fixed error word.

---
 rtl/data_mem_pkg.sv | 11 +
 rtl/data_mem.sv | 52 +++++
 tb/tb_data_mem.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants for the byte-addressable data RAM.
//   MEM_SIZE_BYTES - byte capacity, valid addresses 0..MEM_SIZE_BYTES-1
//   ADDR_IDX_W     - width of a byte index into the array
//   IDLE_WORD      - read word returned after any non-read cycle
//   OOR_WORD       - read word returned after an out-of-range read
package data_mem_pkg;
    localparam int unsigned MEM_SIZE_BYTES = 4096;
    localparam int unsigned ADDR_IDX_W     = 12;
    localparam logic [31:0] IDLE_WORD      = 32'hFA11_1EAF;
    localparam logic [31:0] OOR_WORD       = 32'hDEAD_BEEF;
endpackage

// File: rtl/data_mem.sv
// data_mem: 4 KiB little-endian byte RAM on the LSU data port, registered 1-cycle read.
//   clk_i          - clock, all state changes on the rising edge
//   rst_ni         - asynchronous active-low reset (read register only)
//   mem_req_i      - access request this cycle
//   write_enable_i - 1 = write, 0 = read (qualified by mem_req_i)
//   addr_i         - byte address, any alignment
//   write_data_i   - write word, little-endian
//   read_data_o    - registered read word
module data_mem
    import data_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o
);
    logic [7:0]            mem_q [MEM_SIZE_BYTES];
    logic [ADDR_IDX_W-1:0] lane_idx [4];
    logic                  in_range;
    logic [31:0]           read_data_d;
    logic [31:0]           read_data_q;

    // 12-bit addition wraps naturally, giving the mod-4096 lane index.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane_idx[g] = addr_i[ADDR_IDX_W-1:0] + ADDR_IDX_W'(g);
    end

    // Full 32-bit compare so high address bits never alias into the array.
    assign in_range = addr_i < 32'(MEM_SIZE_BYTES);

    always_ff @(posedge clk_i) begin
        if (mem_req_i && write_enable_i && in_range)
            for (int k = 0; k < 4; k++)
                mem_q[lane_idx[k]] <= write_data_i[8*k +: 8];
    end

    always_comb begin
        read_data_d = !mem_req_i || write_enable_i ? IDLE_WORD :
                      !in_range                    ? OOR_WORD  :
                      {mem_q[lane_idx[3]], mem_q[lane_idx[2]], mem_q[lane_idx[1]], mem_q[lane_idx[0]]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) read_data_q <= IDLE_WORD;
        else         read_data_q <= read_data_d;
    end

    assign read_data_o = read_data_q;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized self-checking bench for data_mem against a byte-array model.
module tb_data_mem;
    import data_mem_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] write_data_i = '0;
    logic [31:0] read_data_o;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] mem_m [4096];
    bit         known [4096];

    always #5 clk_i = ~clk_i;

    data_mem dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .mem_req_i      (mem_req_i),
        .write_enable_i (write_enable_i),
        .addr_i         (addr_i),
        .write_data_i   (write_data_i),
        .read_data_o    (read_data_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One access: drive at negedge, sample just after posedge, scramble addr/data
    // mid-cycle, and confirm the output did not move by the next negedge.
    task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] rd);
        logic [31:0] v;
        mem_req_i = req;
        write_enable_i = we;
        addr_i = addr;
        write_data_i = data;
        @(posedge clk_i);
        #1;
        v = read_data_o;
        addr_i = $urandom;
        write_data_i = $urandom;
        @(negedge clk_i);
        rd = read_data_o;
        check_eq("hold", rd, v);
    endtask

    task automatic op(input string tag, input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rd);
        logic [31:0] exp, mask;
        int idx;
        cycle(req, we, addr, data, rd);
        if (!req || we) begin
            check_eq({tag, "_idle"}, rd, IDLE_WORD);
            if (req && addr < 4096)
                for (int k = 0; k < 4; k++) begin
                    idx = (int'(addr) + k) % 4096;
                    mem_m[idx] = data[8*k +: 8];
                    known[idx] = 1'b1;
                end
        end else if (addr >= 4096) begin
            check_eq({tag, "_oor"}, rd, OOR_WORD);
        end else begin
            exp = '0;
            mask = '0;
            for (int k = 0; k < 4; k++) begin
                idx = (int'(addr) + k) % 4096;
                if (known[idx]) begin
                    mask[8*k +: 8] = 8'hFF;
                    exp[8*k +: 8] = mem_m[idx];
                end
            end
            if (mask != 0) check_eq(tag, rd & mask, exp);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        req, we;
        #12;
        check_eq("reset", read_data_o, IDLE_WORD);
        @(negedge clk_i);
        rst_ni = 1'b1;

        cycle(1'b1, 1'b0, 32'd1, 32'd0, rd);
        check_eq("uninit_not_word", {31'b0, rd !== IDLE_WORD && rd !== OOR_WORD}, 32'd1);
        #2 rst_ni = 1'b0;
        #1 check_eq("async_reset", read_data_o, IDLE_WORD);
        @(negedge clk_i);
        rst_ni = 1'b1;

        op("w8", 1'b1, 1'b1, 32'd8, 32'hA5A5_5A5A, rd);
        op("req0", 1'b0, 1'b0, 32'd8, 32'h0, rd);
        op("req0_we1", 1'b0, 1'b1, 32'd8, 32'h1111_2222, rd);
        op("rd8", 1'b1, 1'b0, 32'd8, 32'h0, rd);
        check_eq("no_write_req0", rd, 32'hA5A5_5A5A);
        op("w12", 1'b1, 1'b1, 32'd12, 32'h0BAD_F00D, rd);
        for (int i = 0; i < 6; i++) begin
            op("stable", 1'b1, 1'b0, 32'd12, 32'h0, rd);
            check_eq("stable_val", rd, 32'h0BAD_F00D);
        end

        op("w0", 1'b1, 1'b1, 32'd0, 32'h7654_3210, rd);
        op("w4", 1'b1, 1'b1, 32'd4, 32'hFECD_BA98, rd);
        op("rd2", 1'b1, 1'b0, 32'd2, 32'h0, rd);
        check_eq("misaligned", rd, 32'hBA98_7654);

        mem_req_i = 1'b1;
        write_enable_i = 1'b0;
        addr_i = 32'd2;
        @(posedge clk_i);
        #1 addr_i = 32'd0;
        @(negedge clk_i);
        check_eq("sync_hold", read_data_o, 32'hBA98_7654);
        @(posedge clk_i);
        #1 check_eq("sync_next", read_data_o, 32'h7654_3210);
        @(negedge clk_i);

        op("oor4096", 1'b1, 1'b0, 32'd4096, 32'h0, rd);
        op("oor_top", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, rd);
        op("oor_alias", 1'b1, 1'b0, 32'h1000_0002, 32'h0, rd);
        op("w4096", 1'b1, 1'b1, 32'd4096, 32'hDEAD_DEAD, rd);
        op("w_alias", 1'b1, 1'b1, 32'h0001_0000, 32'h1234_5678, rd);
        op("rd0_after_oor", 1'b1, 1'b0, 32'd0, 32'h0, rd);
        check_eq("oor_no_write", rd, 32'h7654_3210);

        op("w4094", 1'b1, 1'b1, 32'd4094, 32'h4433_2211, rd);
        op("rd4094", 1'b1, 1'b0, 32'd4094, 32'h0, rd);
        check_eq("wrap_rd", rd, 32'h4433_2211);
        op("rd0_wrap", 1'b1, 1'b0, 32'd0, 32'h0, rd);
        check_eq("wrap_wr", rd, 32'h7654_4433);

        for (int a = 0; a < 4096; a++) begin
            req = $urandom_range(0, 3) != 0;
            we = 1'($urandom_range(0, 1));
            op("sweep", req, we, 32'(a), $urandom, rd);
        end
        for (int i = 0; i < 600; i++) begin
            we = $urandom_range(0, 3) == 0;
            op("rand", 1'b1, we, i % 50 == 0 ? 32'd4096 + $urandom_range(0, 9) : 32'($urandom_range(0, 4095)),
               $urandom, rd);
        end

        op("final_idle", 1'b0, 1'b0, 32'd0, 32'h0, rd);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
